// File: rtl/sram_controller.sv
// Two-phase 32-bit <-> 16-bit asynchronous SRAM sequencer with wait states and pipeline freeze.
// Optional build macro SRAM_PERF_CNT_EN adds access and stall counters.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        sram_freeze,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
`ifdef SRAM_PERF_CNT_EN
  ,
  output logic [31:0] acc_count,
  output logic [31:0] stall_count
`endif
);

  // Handshake: the MEM stage holds rd_en/wr_en (with address/write_data) high
  // until ready pulses; the access is latched leaving IDLE and always runs to
  // completion, so ready acts as the accept-and-complete strobe for one request.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] word_idx;
  logic        phase_last;

  assign word_idx   = 16'((address - 32'(BASE_ADDR)) >> 2);
  assign phase_last = (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          state_d = WR_LO;
          addr_d  = word_idx;
          wdata_d = write_data;
        end else if (rd_en) begin
          state_d = RD_LO;
          addr_d  = word_idx;
          wdata_d = write_data;
        end
      end
      RD_LO: begin
        if (phase_last) begin
          state_d        = RD_HI;
          cnt_d          = '0;
          rdata_d[15:0]  = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RD_HI: begin
        if (phase_last) begin
          state_d        = DONE;
          cnt_d          = '0;
          rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_LO: begin
        if (phase_last) begin
          state_d = WR_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_HI: begin
        if (phase_last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are decoded from the current state so reset releases them at once.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state_q)
      RD_LO: sram_addr = {1'b0, addr_q, 1'b0};
      RD_HI: sram_addr = {1'b0, addr_q, 1'b1};
      WR_LO: begin
        sram_addr   = {1'b0, addr_q, 1'b0};
        sram_dq_out = wdata_q[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
      WR_HI: begin
        sram_addr   = {1'b0, addr_q, 1'b1};
        sram_dq_out = wdata_q[31:16];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
      end
      default: ;
    endcase
  end

  assign ready       = (state_q == DONE);
  assign read_data   = rdata_q;
  assign sram_freeze = (rd_en | wr_en) & ~ready;

`ifdef SRAM_PERF_CNT_EN
  logic [31:0] acc_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (ready)       acc_q   <= acc_q + 32'd1;
      if (sram_freeze) stall_q <= stall_q + 32'd1;
    end
  end

  assign acc_count   = acc_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: three instances with WAIT_CYCLES = 1, 2, 3, each
// behind its own 16-bit SRAM model, checked against a 32-bit word-level reference.
module tb_sram_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd_en_w   [1:3];
  logic        wr_en_w   [1:3];
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] rdata_w   [1:3];
  logic        ready_w   [1:3];
  logic        freeze_w  [1:3];
  logic [17:0] saddr_w   [1:3];
  logic [15:0] dq_out_w  [1:3];
  logic [15:0] dq_in_w   [1:3];
  logic        oe_w      [1:3];
  logic        we_n_w    [1:3];
`ifdef SRAM_PERF_CNT_EN
  logic [31:0] acc_w     [1:3];
  logic [31:0] stall_w   [1:3];
`endif

  // 16-bit SRAM models, 256 half-words each, plus a preload port
  logic [15:0] mem [1:3][0:255];
  logic        pre_en;
  int          pre_n;
  logic [6:0]  pre_w;
  logic [31:0] pre_d;

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_n][{pre_w, 1'b0}] <= pre_d[15:0];
      mem[pre_n][{pre_w, 1'b1}] <= pre_d[31:16];
    end
    for (int n = 1; n <= 3; n++)
      if (we_n_w[n] === 1'b0) mem[n][saddr_w[n][7:0]] <= dq_out_w[n];
  end

  assign dq_in_w[1] = mem[1][saddr_w[1][7:0]];
  assign dq_in_w[2] = mem[2][saddr_w[2][7:0]];
  assign dq_in_w[3] = mem[3][saddr_w[3][7:0]];

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .rd_en(rd_en_w[1]), .wr_en(wr_en_w[1]),
    .address(address), .write_data(write_data), .read_data(rdata_w[1]),
    .ready(ready_w[1]), .sram_freeze(freeze_w[1]), .sram_addr(saddr_w[1]),
    .sram_dq_out(dq_out_w[1]), .sram_dq_in(dq_in_w[1]), .sram_dq_oe(oe_w[1]),
    .sram_we_n(we_n_w[1])
`ifdef SRAM_PERF_CNT_EN
    , .acc_count(acc_w[1]), .stall_count(stall_w[1])
`endif
  );

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .rd_en(rd_en_w[2]), .wr_en(wr_en_w[2]),
    .address(address), .write_data(write_data), .read_data(rdata_w[2]),
    .ready(ready_w[2]), .sram_freeze(freeze_w[2]), .sram_addr(saddr_w[2]),
    .sram_dq_out(dq_out_w[2]), .sram_dq_in(dq_in_w[2]), .sram_dq_oe(oe_w[2]),
    .sram_we_n(we_n_w[2])
`ifdef SRAM_PERF_CNT_EN
    , .acc_count(acc_w[2]), .stall_count(stall_w[2])
`endif
  );

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .rd_en(rd_en_w[3]), .wr_en(wr_en_w[3]),
    .address(address), .write_data(write_data), .read_data(rdata_w[3]),
    .ready(ready_w[3]), .sram_freeze(freeze_w[3]), .sram_addr(saddr_w[3]),
    .sram_dq_out(dq_out_w[3]), .sram_dq_in(dq_in_w[3]), .sram_dq_oe(oe_w[3]),
    .sram_we_n(we_n_w[3])
`ifdef SRAM_PERF_CNT_EN
    , .acc_count(acc_w[3]), .stall_count(stall_w[3])
`endif
  );

  // Reference model: 32-bit words per instance and the last loaded value
  logic [31:0] ref_mem [1:3][0:127];
  logic [31:0] last_rd [1:3];
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic preload(input int n, input logic [6:0] widx, input logic [31:0] data);
    pre_n = n; pre_w = widx; pre_d = data; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
    ref_mem[n][widx] = data;
  endtask

  // op: 0 = load, 1 = store, 2 = both requests high (store wins).
  // hold keeps the request asserted past ready so the next call starts back-to-back.
  task automatic do_access(input int n, input int op, input logic [6:0] widx,
                           input logic [31:0] data, input bit hold);
    int w;
    bit in_lo, in_hi, wr_ph, e_ready;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    logic [31:0] e_rd;
    w = n;
    if (op == 0) begin
      exp_q.push_back(ref_mem[n][widx]);
      last_rd[n] = ref_mem[n][widx];
    end else begin
      exp_q.push_back(last_rd[n]);
      ref_mem[n][widx] = data;
    end
    @(posedge clk); #1;
    address    = 32'd1024 + {23'd0, widx, 2'b00};
    write_data = data;
    rd_en_w[n] = (op != 1);
    wr_en_w[n] = (op != 0);
    for (int k = 0; k <= 2 * w + 1; k++) begin
      @(negedge clk);
      in_lo   = (k >= 1) && (k <= w);
      in_hi   = (k > w) && (k <= 2 * w);
      wr_ph   = (op != 0) && (in_lo || in_hi);
      e_ready = (k == 2 * w + 1);
      e_addr  = (in_lo || in_hi) ? (18'(widx) * 18'd2 + (in_hi ? 18'd1 : 18'd0)) : 18'd0;
      e_dq    = wr_ph ? (in_hi ? data[31:16] : data[15:0]) : 16'd0;
      n_checks++;
      if (ready_w[n] !== e_ready) begin
        n_errors++;
        $display("FAIL ready w=%0d op=%0d cyc=%0d got=%b exp=%b", w, op, k, ready_w[n], e_ready);
      end
      n_checks++;
      if (freeze_w[n] !== !e_ready) begin
        n_errors++;
        $display("FAIL freeze w=%0d op=%0d cyc=%0d got=%b exp=%b", w, op, k, freeze_w[n], !e_ready);
      end
      n_checks++;
      if (saddr_w[n] !== e_addr) begin
        n_errors++;
        $display("FAIL sram_addr w=%0d op=%0d cyc=%0d got=%0h exp=%0h", w, op, k, saddr_w[n], e_addr);
      end
      n_checks++;
      if (we_n_w[n] !== !wr_ph) begin
        n_errors++;
        $display("FAIL we_n w=%0d op=%0d cyc=%0d got=%b exp=%b", w, op, k, we_n_w[n], !wr_ph);
      end
      n_checks++;
      if (oe_w[n] !== wr_ph) begin
        n_errors++;
        $display("FAIL dq_oe w=%0d op=%0d cyc=%0d got=%b exp=%b", w, op, k, oe_w[n], wr_ph);
      end
      n_checks++;
      if (dq_out_w[n] !== e_dq) begin
        n_errors++;
        $display("FAIL dq_out w=%0d op=%0d cyc=%0d got=%0h exp=%0h", w, op, k, dq_out_w[n], e_dq);
      end
      if (e_ready) begin
        e_rd = exp_q.pop_front();
        n_checks++;
        if (rdata_w[n] !== e_rd) begin
          n_errors++;
          $display("FAIL read_data w=%0d op=%0d got=%h exp=%h", w, op, rdata_w[n], e_rd);
        end
      end
    end
    if (!hold) begin
      @(posedge clk); #1;
      rd_en_w[n] = 1'b0;
      wr_en_w[n] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_en_w[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int n = 1; n <= 3; n++) begin
      n_checks++;
      if (rdata_w[n] !== 32'd0 || ready_w[n] !== 1'b0 || saddr_w[n] !== 18'd0 ||
          dq_out_w[n] !== 16'd0 || oe_w[n] !== 1'b0 || we_n_w[n] !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_outputs w=%0d got rd=%h rdy=%b a=%0h dq=%0h oe=%b we_n=%b exp 0/0/0/0/0/1",
                 n, rdata_w[n], ready_w[n], saddr_w[n], dq_out_w[n], oe_w[n], we_n_w[n]);
      end
      n_checks++;
      if (freeze_w[n] !== (n == 1)) begin
        n_errors++;
        $display("FAIL reset_freeze w=%0d got=%b exp=%b", n, freeze_w[n], (n == 1));
      end
    end
    #1;
    rd_en_w[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 1; n <= 3; n++) last_rd[n] = 32'd0;
  endtask

  task automatic test_read_basic();
    preload(2, 7'd0, 32'h1234_5678);
    do_access(2, 0, 7'd0, 32'd0, 1'b0);
  endtask

  task automatic test_write_basic();
    do_access(2, 1, 7'd1, 32'hDEAD_BEEF, 1'b0);
    do_access(2, 0, 7'd1, 32'd0, 1'b0);
  endtask

  task automatic test_both_requests();
    do_access(2, 2, 7'd9, 32'hCAFE_F00D, 1'b0);
    do_access(2, 0, 7'd9, 32'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_access(1, 0, 7'd3, 32'd0, 1'b1);
    do_access(1, 0, 7'd4, 32'd0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 45; i++)
      do_access($urandom_range(1, 3), $urandom_range(0, 2), 7'($urandom_range(0, 15)),
                $urandom, 1'b0);
  endtask

  task automatic test_rst_abort();
    logic [31:0] d;
    bit seen;
    d = $urandom;
    @(posedge clk); #1;
    address    = 32'd1024 + 32'd20;
    write_data = d;
    wr_en_w[3] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    wr_en_w[3] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (we_n_w[3] !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_pre_we_n got=%b exp=0", we_n_w[3]);
    end
    @(negedge clk);
    n_checks++;
    if (we_n_w[3] !== 1'b1 || oe_w[3] !== 1'b0 || saddr_w[3] !== 18'd0 || ready_w[3] !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_idle got we_n=%b oe=%b a=%0h rdy=%b exp 1/0/0/0",
               we_n_w[3], oe_w[3], saddr_w[3], ready_w[3]);
    end
    #1;
    rst = 1'b0;
    ref_mem[3][5][15:0] = d[15:0];
    for (int n = 1; n <= 3; n++) last_rd[n] = 32'd0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ready_w[3] !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("FAIL abort_no_ready got=pulse exp=none");
    end
    do_access(3, 0, 7'd5, 32'd0, 1'b0);
  endtask

`ifdef SRAM_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 1; n <= 3; n++) last_rd[n] = 32'd0;
    do_access(2, 0, 7'd2, 32'd0, 1'b0);
    do_access(2, 0, 7'd6, 32'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (acc_w[2] !== 32'd2) begin
      n_errors++;
      $display("FAIL acc_count got=%0d exp=2", acc_w[2]);
    end
    n_checks++;
    if (stall_w[2] !== 32'd10) begin
      n_errors++;
      $display("FAIL stall_count got=%0d exp=10", stall_w[2]);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    pre_en = 1'b0; pre_n = 1; pre_w = '0; pre_d = '0;
    address = '0; write_data = '0;
    for (int n = 1; n <= 3; n++) begin
      rd_en_w[n] = 1'b0;
      wr_en_w[n] = 1'b0;
      for (int i = 0; i < 128; i++) preload(n, 7'(i), $urandom);
    end
    test_reset();
    test_read_basic();
    test_write_basic();
    test_both_requests();
    test_back_to_back();
    test_random();
    test_rst_abort();
`ifdef SRAM_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
